colorled_blink_sched: RTL and testbench
=======================================

Name: colorled_blink_sched

Overview:
Scheduler for the colour status LED. Up to N_REQ status sources request a display mode for the single LED. The block arbitrates them by fixed priority and sequences the chosen pattern (off / steady / slow blink / fast blink) on a prescaled tick. It drives the active-low LED line (0 = lamp on, 1 = lamp off) and sits between the status logic and the LED pin.

Parameters:
CLK_DIV, 50000, clk cycles per tick (>=1); the tick is a one-cycle pulse when the prescaler wraps.
N_REQ, 4, number of requesters (1..8).
SLOW_HALF, 500, ticks per half-period of slow blink (>=1).
FAST_HALF, 125, ticks per half-period of fast blink (>=1).
PWM_BITS, 4, dimming resolution (optional feature only).

Ports:
clk  in  1  system clock
aresetn  in  1  asynchronous reset, active-low
i_req  in  N_REQ  per-requester request; bit 0 = highest priority
i_mode  in  2*N_REQ  per-requester mode, field k = bits [2k+1:2k]: 00 off, 01 steady, 10 slow blink, 11 fast blink
o_colLed  out  1  LED drive, active-low (0 = lamp on)
o_grant  out  N_REQ  one-hot owner of the LED; 0 when idle
o_busy  out  1  1 when any requester holds the grant
o_period  out  1  one-clk pulse at the end of each full blink period

Behaviour:
- Reset (async, aresetn=0): prescaler=0, phase counter=0, state IDLE, o_colLed=1, o_grant=0, o_busy=0, o_period=0. Outputs take these values immediately, with no clock edge needed. Release is synchronous to clk.
- Prescaler counts 0..CLK_DIV-1 and then wraps; tick=1 on the wrap cycle. With CLK_DIV=1, tick=1 every cycle.
- Arbitration and all state changes happen only on tick cycles. The winner is the lowest set index of i_req. Between ticks, i_req and i_mode are ignored.
- FSM states: IDLE, DARK, STEADY, BLINK_ON, BLINK_OFF.
- On tick with no request: go to IDLE; o_grant=0, o_busy=0.
- On tick with a request, compare winner index and winner mode against the latched values.
  - Both equal: continue the current pattern.
  - Either differs, or the state is IDLE: latch the new index and mode, clear the phase counter, and enter the mode's start state: 00 -> DARK, 01 -> STEADY, 10/11 -> BLINK_ON.
- BLINK_ON / BLINK_OFF:
  - The phase counter increments on each tick.
  - When it reaches HALF-1 on a tick (HALF = SLOW_HALF or FAST_HALF), the counter clears and the state toggles.
  - BLINK_OFF -> BLINK_ON also pulses o_period for that one clk.
  - The counter also clears on a preemption.
- o_colLed = 0 in STEADY and BLINK_ON; 1 in IDLE, DARK and BLINK_OFF.
- All outputs are registered; they update on the clk edge that samples the tick (latency 1 clk from tick).
- Preemption mid-phase: a higher-priority request takes over at the next tick, and its pattern restarts from the start state.
- Deassertion of the holder mid-phase: at the next tick the next-lowest pending index wins, or IDLE if none.
- Mode change by the current holder: the pattern restarts at the next tick.
- Simultaneous phase end and preemption on the same tick: preemption wins and o_period is not pulsed.

Optional Feature:
Macro COLORLED_PWM_DIM_EN.
- Defined:
  - Adds input i_dim [PWM_BITS-1:0] and a free-running PWM_BITS-wide counter on clk, reset to 0.
  - In on-states, o_colLed=0 only while counter < i_dim, otherwise 1.
  - i_dim=0 keeps the lamp dark; all-ones gives (2^PWM_BITS-1)/2^PWM_BITS duty.
  - Off-states are unaffected.
- Undefined: i_dim and the PWM counter are absent; on-states drive 0 continuously.

Test Plan (CLK_DIV=4, SLOW_HALF=4, FAST_HALF=2, N_REQ=4):
1. aresetn=0 with arbitrary inputs -> o_colLed=1, o_grant=0000, o_busy=0, o_period=0. Release: no change until a request is made.
2. i_req=0100, i_mode field2=10 -> after the first tick: o_grant=0100, o_busy=1, o_colLed=0 for 16 clk, then 1 for 16 clk. o_period pulses one clk at the 32-clk boundary, and the pattern repeats.
3. Item 2 running in BLINK_OFF, then i_req=0101 with field0=01 -> at the next tick: o_grant=0001, o_colLed=0 steady, no o_period pulse.
4. Field0 switched to 11 while holding -> the pattern restarts in BLINK_ON: 8 clk on, 8 clk off. Drop i_req to 0000 -> next tick: o_colLed=1, o_grant=0000, o_busy=0.
5. aresetn pulsed low for 2 clk mid BLINK_ON -> o_colLed=1 and o_grant=0 asynchronously. After release with a request still held, the block re-arbitrates at the first tick, 4 clk later.
6. COLORLED_PWM_DIM_EN defined, steady mode, i_dim=4 -> o_colLed=0 for 4 of every 16 clk. i_dim=0 -> o_colLed stays 1.

Source files
------------

// File: rtl/colorled_blink_sched.sv
// Colour status LED scheduler: fixed-priority arbitration of N_REQ sources and
// tick-paced off/steady/slow/fast patterns. Define COLORLED_PWM_DIM_EN for PWM dimming.
module colorled_blink_sched #(
    parameter int CLK_DIV   = 50000,
    parameter int N_REQ     = 4,
    parameter int SLOW_HALF = 500,
    parameter int FAST_HALF = 125
`ifdef COLORLED_PWM_DIM_EN
    ,
    parameter int PWM_BITS  = 4
`endif
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [2*N_REQ-1:0] i_mode,
`ifdef COLORLED_PWM_DIM_EN
    input  logic [PWM_BITS-1:0] i_dim,
`endif
    output logic               o_colLed,
    output logic [N_REQ-1:0]   o_grant,
    output logic               o_busy,
    output logic               o_period
);

    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int PH_W     = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;
    localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, DARK, STEADY, BLINK_ON, BLINK_OFF} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [PH_W-1:0]  ph_q, ph_d, half_m1;
    logic [IDX_W-1:0] idx_q, idx_d, win_idx;
    logic [1:0]       mode_q, mode_d, win_mode;
    logic             win_vld, tick, period_d, on_d, led_on_d, busy_d;
    logic [N_REQ-1:0] grant_d;

    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)  div_q <= '0;
        else if (tick) div_q <= '0;
        else           div_q <= div_q + 1'b1;
    end

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        win_mode = 2'b00;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                win_vld  = 1'b1;
                win_idx  = IDX_W'(k);
                win_mode = i_mode[2*k +: 2];
            end
        end
    end

    assign half_m1 = mode_q[0] ? PH_W'(FAST_HALF - 1) : PH_W'(SLOW_HALF - 1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mode_d   = mode_q;
        ph_d     = ph_q;
        period_d = 1'b0;
        if (tick) begin
            if (!win_vld) begin
                state_d = IDLE;
                ph_d    = '0;
            end else if (state_q != IDLE && win_idx == idx_q && win_mode == mode_q) begin
                if (state_q == BLINK_ON || state_q == BLINK_OFF) begin
                    if (ph_q == half_m1) begin
                        ph_d     = '0;
                        state_d  = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                        period_d = (state_q == BLINK_OFF);
                    end else begin
                        ph_d = ph_q + 1'b1;
                    end
                end
            end else begin
                // New owner or new mode: pattern restarts from its start state.
                idx_d  = win_idx;
                mode_d = win_mode;
                ph_d   = '0;
                case (win_mode)
                    2'b00:   state_d = DARK;
                    2'b01:   state_d = STEADY;
                    default: state_d = BLINK_ON;
                endcase
            end
        end
    end

    assign on_d    = (state_d == STEADY) || (state_d == BLINK_ON);
    assign busy_d  = (state_d != IDLE);
    assign grant_d = busy_d ? (N_REQ'(1) << idx_d) : '0;

`ifdef COLORLED_PWM_DIM_EN
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    assign pwm_d    = pwm_q + 1'b1;
    // Compare against the counter value that will be current when the LED flop updates.
    assign led_on_d = on_d && (pwm_d < i_dim);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) pwm_q <= '0;
        else          pwm_q <= pwm_d;
    end
`else
    assign led_on_d = on_d;
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            mode_q   <= 2'b00;
            ph_q     <= '0;
            o_colLed <= 1'b1;
            o_grant  <= '0;
            o_busy   <= 1'b0;
            o_period <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            ph_q     <= ph_d;
            o_colLed <= ~led_on_d;
            o_grant  <= grant_d;
            o_busy   <= busy_d;
            o_period <= period_d;
        end
    end

endmodule

// File: tb/tb_colorled_blink_sched.sv
// Vector-table and scoreboard bench for colorled_blink_sched (CLK_DIV=4, SLOW_HALF=4, FAST_HALF=2).
module tb_colorled_blink_sched;

    logic       clk = 1'b0;
    logic       aresetn;
    logic [3:0] i_req;
    logic [7:0] i_mode;
    logic       o_colLed;
    logic [3:0] o_grant;
    logic       o_busy;
    logic       o_period;
`ifdef COLORLED_PWM_DIM_EN
    logic [3:0] i_dim;
`endif

    colorled_blink_sched #(
        .CLK_DIV(4), .N_REQ(4), .SLOW_HALF(4), .FAST_HALF(2)
    ) dut (
        .clk(clk), .aresetn(aresetn), .i_req(i_req), .i_mode(i_mode),
`ifdef COLORLED_PWM_DIM_EN
        .i_dim(i_dim),
`endif
        .o_colLed(o_colLed), .o_grant(o_grant), .o_busy(o_busy), .o_period(o_period)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       led;
        logic [3:0] grant;
        logic       busy;
        logic       period;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic [7:0] mode;
        int         adv;
        exp_t       exp;
    } vec_t;

    vec_t vecs[22];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name);
        exp_t e, a;
        e = sb.pop_front();
        a = '{o_colLed, o_grant, o_busy, o_period};
`ifdef COLORLED_PWM_DIM_EN
        if (!e.led) a.led = 1'b0;   // on-state lamp is PWM-gated in this build
`endif
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got led=%b grant=%b busy=%b period=%b, want led=%b grant=%b busy=%b period=%b",
                     name, a.led, a.grant, a.busy, a.period, e.led, e.grant, e.busy, e.period);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        // Edge E counts posedges after release; ticks fall on E = 4, 8, 12, ...
        vecs[0]  = '{4'b0000, 8'h00,  8, '{1'b1, 4'b0000, 1'b0, 1'b0}}; // E8 idle
        vecs[1]  = '{4'b0100, 8'h20,  4, '{1'b0, 4'b0100, 1'b1, 1'b0}}; // E12 slow ON
        vecs[2]  = '{4'b0100, 8'h20, 15, '{1'b0, 4'b0100, 1'b1, 1'b0}}; // E27 last on clk
        vecs[3]  = '{4'b0100, 8'h20,  1, '{1'b1, 4'b0100, 1'b1, 1'b0}}; // E28 OFF
        vecs[4]  = '{4'b0100, 8'h20, 15, '{1'b1, 4'b0100, 1'b1, 1'b0}}; // E43 last off clk
        vecs[5]  = '{4'b0100, 8'h20,  1, '{1'b0, 4'b0100, 1'b1, 1'b1}}; // E44 period pulse
        vecs[6]  = '{4'b0100, 8'h20,  1, '{1'b0, 4'b0100, 1'b1, 1'b0}}; // E45 pulse gone
        vecs[7]  = '{4'b0100, 8'h20, 15, '{1'b1, 4'b0100, 1'b1, 1'b0}}; // E60 OFF
        vecs[8]  = '{4'b0100, 8'h20, 15, '{1'b1, 4'b0100, 1'b1, 1'b0}}; // E75 OFF, phase end due
        vecs[9]  = '{4'b0101, 8'h21,  1, '{1'b0, 4'b0001, 1'b1, 1'b0}}; // E76 preempt beats period
        vecs[10] = '{4'b0101, 8'h21,  1, '{1'b0, 4'b0001, 1'b1, 1'b0}}; // E77
        vecs[11] = '{4'b0101, 8'h21,  8, '{1'b0, 4'b0001, 1'b1, 1'b0}}; // E85 steady
        vecs[12] = '{4'b0101, 8'h23,  3, '{1'b0, 4'b0001, 1'b1, 1'b0}}; // E88 fast restart
        vecs[13] = '{4'b0101, 8'h23,  7, '{1'b0, 4'b0001, 1'b1, 1'b0}}; // E95
        vecs[14] = '{4'b0101, 8'h23,  1, '{1'b1, 4'b0001, 1'b1, 1'b0}}; // E96 fast OFF
        vecs[15] = '{4'b0101, 8'h23,  7, '{1'b1, 4'b0001, 1'b1, 1'b0}}; // E103
        vecs[16] = '{4'b0101, 8'h23,  1, '{1'b0, 4'b0001, 1'b1, 1'b1}}; // E104 fast period
        vecs[17] = '{4'b0100, 8'h23,  3, '{1'b0, 4'b0001, 1'b1, 1'b0}}; // E107 drop ignored off-tick
        vecs[18] = '{4'b0100, 8'h23,  1, '{1'b0, 4'b0100, 1'b1, 1'b0}}; // E108 next pending wins
        vecs[19] = '{4'b0000, 8'h23,  4, '{1'b1, 4'b0000, 1'b0, 1'b0}}; // E112 idle
        vecs[20] = '{4'b1000, 8'h00,  4, '{1'b1, 4'b1000, 1'b1, 1'b0}}; // E116 dark, busy
        vecs[21] = '{4'b1111, 8'h04,  4, '{1'b1, 4'b0001, 1'b1, 1'b0}}; // E120 bit0 wins, dark

        aresetn = 1'b0;
        i_req   = 4'b1011;
        i_mode  = 8'hFF;
`ifdef COLORLED_PWM_DIM_EN
        i_dim   = 4'hF;
`endif
        repeat (3) @(negedge clk);
        sb.push_back('{1'b1, 4'b0000, 1'b0, 1'b0});
        chk("reset_state");
        i_req  = 4'b0000;
        i_mode = 8'h00;
        aresetn = 1'b1;

        foreach (vecs[i]) begin
            i_req  = vecs[i].req;
            i_mode = vecs[i].mode;
            sb.push_back(vecs[i].exp);
            repeat (vecs[i].adv) @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d", i));
        end

        // Slow blink on owner 0, then async reset mid BLINK_ON.
        i_req  = 4'b0001;
        i_mode = 8'h02;
        sb.push_back('{1'b0, 4'b0001, 1'b1, 1'b0});
        repeat (4) @(posedge clk);                           // E124
        @(negedge clk);
        chk("blink_before_reset");
        #2 aresetn = 1'b0;
        sb.push_back('{1'b1, 4'b0000, 1'b0, 1'b0});
        #1 chk("async_reset");
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        sb.push_back('{1'b1, 4'b0000, 1'b0, 1'b0});
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post_reset_no_tick");
        sb.push_back('{1'b0, 4'b0001, 1'b1, 1'b0});
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_first_tick");

`ifdef COLORLED_PWM_DIM_EN
        begin
            int lit;
            i_mode = 8'h01;
            i_dim  = 4'd4;
            repeat (8) @(negedge clk);
            lit = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (!o_colLed) lit++;
            end
            n_vec++;
            if (lit != 4) begin
                n_err++;
                $display("FAIL pwm_dim4: got %0d lit clks of 16, want 4", lit);
            end
            i_dim = 4'd0;
            repeat (2) @(negedge clk);
            lit = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (!o_colLed) lit++;
            end
            n_vec++;
            if (lit != 0) begin
                n_err++;
                $display("FAIL pwm_dim0: got %0d lit clks of 16, want 0", lit);
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
